// File: rtl/proj_pkg.sv
// Shared types and fixed-point helpers for the triangle projector.
// Trig values carry TRIG_W-2 fraction bits, so 1.0 is 2**(TRIG_W-2).
package proj_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_XFORM1,
        S_XFORM2,
        S_DIVIDE,
        S_AREA,
        S_EMIT,
        S_SKIP,
        S_DONE
    } proj_state_t;

    function automatic int trig_frac(input int trig_w);
        return trig_w - 2;
    endfunction

    function automatic int trig_one(input int trig_w);
        return 1 << (trig_w - 2);
    endfunction

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first step happens on the start edge, so done rises DIV_W cycles later.
module seq_divider #(
    parameter int DIV_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem;
    logic [DIV_W-1:0] dsr;
    logic [DIV_W-1:0] q_in;
    logic [DIV_W-1:0] r_in;
    logic [DIV_W-1:0] d_in;
    logic [DIV_W-1:0] q_nx;
    logic [DIV_W-1:0] r_nx;
    logic [DIV_W:0]   shifted;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        q_in    = start ? dividend : quotient;
        r_in    = start ? '0 : rem;
        d_in    = start ? divisor : dsr;
        shifted = {r_in, q_in[DIV_W-1]};
        if (shifted >= {1'b0, d_in}) begin
            r_nx = DIV_W'(shifted - {1'b0, d_in});
            q_nx = {q_in[DIV_W-2:0], 1'b1};
        end else begin
            r_nx = shifted[DIV_W-1:0];
            q_nx = {q_in[DIV_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem      <= r_nx;
                quotient <= q_nx;
            end
            if (start) begin
                dsr  <= divisor;
                cnt  <= CNT_W'(1);
                busy <= 1'b1;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIV_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/triangle_projector.sv
// Camera-space triangle projector: translate, yaw-rotate, perspective
// divide with one shared divider, near/backface cull, stream out.
module triangle_projector
    import proj_pkg::*;
#(
    parameter int NUM_TRIS    = 4,
    parameter int COORD_W     = 6,
    parameter int CAM_W       = 7,
    parameter int TRIG_W      = 8,
    parameter int COLOR_W     = 10,
    parameter int FOCAL_SHIFT = 4,
    parameter int OUT_W       = 9,
    parameter int MEM_LAT     = 2,
    parameter int NEAR_Z      = 1,
    localparam int ADDRW = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1,
    localparam int D_W   = ((COORD_W > CAM_W) ? COORD_W : CAM_W) + 1,
    localparam int R_W   = D_W + 2,
    localparam int MW    = 9 * COORD_W + COLOR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3*CAM_W-1:0]   cam_pos,
    input  logic [TRIG_W-1:0]    sin_val,
    input  logic [TRIG_W-1:0]    cos_val,
    input  logic                 backface_en,
    output logic                 mem_en,
    output logic [ADDRW-1:0]     mem_addr,
    input  logic [MW-1:0]        mem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*OUT_W-1:0]   out_tri,
    output logic [R_W-1:0]       out_depth,
    output logic [COLOR_W-1:0]   out_color,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRW:0]       emit_count,
    output logic [ADDRW:0]       cull_count
);

    localparam int DIV_W = R_W + FOCAL_SHIFT;
    localparam int FRAC  = trig_frac(TRIG_W);
    localparam int AW    = 2 * OUT_W + 4;
    localparam int CW    = ADDRW + 1;
    localparam int WCW   = $clog2(MEM_LAT + 1);
    localparam int PW    = D_W + TRIG_W + 1;
    localparam logic [ADDRW-1:0] LAST = ADDRW'(NUM_TRIS - 1);
    localparam logic signed [R_W-1:0] NEAR = R_W'(NEAR_Z);

    proj_state_t state;

    logic signed [CAM_W-1:0]  cam [3];
    logic signed [TRIG_W-1:0] sin_r;
    logic signed [TRIG_W-1:0] cos_r;
    logic                     bf_r;
    logic [WCW-1:0]           wait_cnt;
    logic signed [D_W-1:0]    dv   [9];
    logic signed [D_W-1:0]    dv_n [9];
    logic [COLOR_W-1:0]       col_r;
    logic signed [PW-1:0]     px [3];
    logic signed [PW-1:0]     pz [3];
    logic signed [R_W-1:0]    xr_n [3];
    logic signed [R_W-1:0]    yr_n [3];
    logic signed [R_W-1:0]    zr_n [3];
    logic signed [R_W-1:0]    xr [3];
    logic signed [R_W-1:0]    yr [3];
    logic signed [R_W-1:0]    zr [3];
    logic signed [R_W-1:0]    depth_n;
    logic signed [R_W-1:0]    depth_r;
    logic                     near;
    logic signed [OUT_W-1:0]  pt [6];
    logic [2:0]               div_sel;
    logic                     div_start;
    logic                     div_busy;
    logic                     div_done;
    logic [DIV_W-1:0]         div_q;
    logic [DIV_W-1:0]         div_num;
    logic [DIV_W-1:0]         div_den;
    logic signed [R_W-1:0]    num_s;
    logic [R_W-1:0]           mag;
    logic signed [DIV_W+1:0]  qv;
    logic signed [OUT_W-1:0]  q_sat;
    logic signed [AW-1:0]     area;

    always_comb begin
        for (int n = 0; n < 9; n++) begin
            dv_n[n] = D_W'($signed(mem_data[MW-1-n*COORD_W -: COORD_W]))
                    - D_W'(cam[n%3]);
        end
    end

    always_comb begin
        near    = 1'b0;
        depth_n = '0;
        for (int k = 0; k < 3; k++) begin
            px[k]   = dv[3*k] * cos_r - dv[3*k+2] * sin_r;
            pz[k]   = dv[3*k] * sin_r + dv[3*k+2] * cos_r;
            xr_n[k] = R_W'(px[k] >>> FRAC);
            zr_n[k] = R_W'(pz[k] >>> FRAC);
            yr_n[k] = R_W'(dv[3*k+1]);
            if (zr_n[k] < NEAR) near = 1'b1;
            if (zr_n[k] > depth_n) depth_n = zr_n[k];
        end
    end

    // Magnitude in, sign restored on the way out: truncation toward zero.
    always_comb begin
        num_s   = div_sel[0] ? yr[div_sel[2:1]] : xr[div_sel[2:1]];
        mag     = num_s[R_W-1] ? R_W'(-num_s) : R_W'(num_s);
        div_num = {mag, {FOCAL_SHIFT{1'b0}}};
        div_den = {{FOCAL_SHIFT{1'b0}}, zr[div_sel[2:1]]};
        qv      = $signed({2'b00, div_q});
        if (num_s[R_W-1]) qv = -qv;
        q_sat   = OUT_W'(sat(int'(qv), OUT_W));
    end

    always_comb begin
        area = (AW'(pt[2]) - AW'(pt[0])) * (AW'(pt[5]) - AW'(pt[1]))
             - (AW'(pt[4]) - AW'(pt[0])) * (AW'(pt[3]) - AW'(pt[1]));
    end

    seq_divider #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (div_start),
        .dividend(div_num),
        .divisor (div_den),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            for (int i = 0; i < 3; i++) begin
                cam[i] <= '0;
                xr[i]  <= '0;
                yr[i]  <= '0;
                zr[i]  <= '0;
            end
            for (int i = 0; i < 9; i++) dv[i] <= '0;
            for (int i = 0; i < 6; i++) pt[i] <= '0;
            sin_r      <= '0;
            cos_r      <= '0;
            bf_r       <= 1'b0;
            wait_cnt   <= '0;
            col_r      <= '0;
            depth_r    <= '0;
            div_sel    <= '0;
            div_start  <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            out_valid  <= 1'b0;
            out_tri    <= '0;
            out_depth  <= '0;
            out_color  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            emit_count <= '0;
            cull_count <= '0;
        end else begin
            done      <= 1'b0;
            div_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cam[0]     <= cam_pos[3*CAM_W-1 -: CAM_W];
                        cam[1]     <= cam_pos[2*CAM_W-1 -: CAM_W];
                        cam[2]     <= cam_pos[CAM_W-1:0];
                        sin_r      <= sin_val;
                        cos_r      <= cos_val;
                        bf_r       <= backface_en;
                        emit_count <= '0;
                        cull_count <= '0;
                        mem_addr   <= '0;
                        mem_en     <= 1'b1;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (wait_cnt == WCW'(MEM_LAT - 1)) begin
                        mem_en <= 1'b0;
                        state  <= S_XFORM1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_XFORM1: begin
                    dv    <= dv_n;
                    col_r <= mem_data[COLOR_W-1:0];
                    state <= S_XFORM2;
                end
                S_XFORM2: begin
                    xr      <= xr_n;
                    yr      <= yr_n;
                    zr      <= zr_n;
                    depth_r <= depth_n;
                    if (near) begin
                        state <= S_SKIP;
                    end else begin
                        div_sel   <= '0;
                        div_start <= 1'b1;
                        state     <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        pt[div_sel] <= q_sat;
                        if (div_sel == 3'd5) begin
                            state <= S_AREA;
                        end else begin
                            div_sel   <= div_sel + 3'd1;
                            div_start <= 1'b1;
                        end
                    end
                end
                S_AREA: begin
                    if (bf_r && area <= 0) begin
                        state <= S_SKIP;
                    end else begin
                        out_valid <= 1'b1;
                        out_tri   <= {pt[0], pt[1], pt[2],
                                      pt[3], pt[4], pt[5]};
                        out_depth <= depth_r;
                        out_color <= col_r;
                        state     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        emit_count <= emit_count + CW'(1);
                        if (mem_addr == LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_addr <= mem_addr + ADDRW'(1);
                            mem_en   <= 1'b1;
                            wait_cnt <= '0;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_SKIP: begin
                    cull_count <= cull_count + CW'(1);
                    if (mem_addr == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDRW'(1);
                        mem_en   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_projector.sv
// Directed bench for triangle_projector with a MEM_LAT-deep memory model.
// Outputs are sampled on the falling edge.
module tb_triangle_projector;

    localparam int NT      = 4;
    localparam int COORD_W = 6;
    localparam int CAM_W   = 7;
    localparam int COLOR_W = 10;
    localparam int OUT_W   = 9;
    localparam int R_W     = 10;
    localparam int ADDRW   = 2;
    localparam int MW      = 9 * COORD_W + COLOR_W;
    localparam int TRI_W   = 6 * OUT_W;
    localparam int LAT     = 2 + 2 + 6 * (R_W + 4 + 1) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [3*CAM_W-1:0]   cam_pos;
    logic [7:0]           sin_val;
    logic [7:0]           cos_val;
    logic                 backface_en;
    logic                 mem_en;
    logic [ADDRW-1:0]     mem_addr;
    logic [MW-1:0]        mem_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [TRI_W-1:0]     out_tri;
    logic [R_W-1:0]       out_depth;
    logic [COLOR_W-1:0]   out_color;
    logic                 busy;
    logic                 done;
    logic [ADDRW:0]       emit_count;
    logic [ADDRW:0]       cull_count;

    logic [MW-1:0] mem [NT];
    logic [MW-1:0] s0;
    logic [MW-1:0] s1;

    int total;
    int bad;
    int div_starts;
    int lat;
    int frame_divs;
    int f_emit;
    int f_cull;
    logic [TRI_W-1:0]   q_tri [$];
    logic [COLOR_W-1:0] q_col [$];
    logic [R_W-1:0]     q_dep [$];

    triangle_projector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cam_pos    (cam_pos),
        .sin_val    (sin_val),
        .cos_val    (cos_val),
        .backface_en(backface_en),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tri    (out_tri),
        .out_depth  (out_depth),
        .out_color  (out_color),
        .busy       (busy),
        .done       (done),
        .emit_count (emit_count),
        .cull_count (cull_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) s0 <= mem[mem_addr];
        s1 <= s0;
    end
    assign mem_data = s1;

    always @(posedge clk) begin
        if (dut.div_start) div_starts <= div_starts + 1;
    end

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] tri_word(
        input int ax, input int ay, input int az,
        input int bx, input int by, input int bz,
        input int cx, input int cy, input int cz, input int col);
        return {COORD_W'(ax), COORD_W'(ay), COORD_W'(az),
                COORD_W'(bx), COORD_W'(by), COORD_W'(bz),
                COORD_W'(cx), COORD_W'(cy), COORD_W'(cz),
                COLOR_W'(col)};
    endfunction

    function automatic int fld(input logic [TRI_W-1:0] t, input int n);
        logic signed [OUT_W-1:0] f;
        f = t[TRI_W-1-n*OUT_W -: OUT_W];
        return int'(f);
    endfunction

    task automatic chk_tri(input string tag, input int k,
                           input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2);
        logic [TRI_W-1:0] t;
        t = (k < q_tri.size()) ? q_tri[k] : '0;
        chk({tag, "_x0"}, fld(t, 0), x0);
        chk({tag, "_y0"}, fld(t, 1), y0);
        chk({tag, "_x1"}, fld(t, 2), x1);
        chk({tag, "_y1"}, fld(t, 3), y1);
        chk({tag, "_x2"}, fld(t, 4), x2);
        chk({tag, "_y2"}, fld(t, 5), y2);
    endtask

    task automatic run_frame(input bit rnd, input bit poke);
        int t_mem;
        int t_val;
        int d0;
        bit held;
        bit seen;
        logic [TRI_W-1:0]   h_tri;
        logic [R_W-1:0]     h_dep;
        logic [COLOR_W-1:0] h_col;
        q_tri.delete();
        q_col.delete();
        q_dep.delete();
        t_mem = -1;
        t_val = -1;
        held  = 1'b0;
        seen  = 1'b0;
        d0    = div_starts;
        h_tri = '0;
        h_dep = '0;
        h_col = '0;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_tri", out_tri, h_tri);
                chk("hold_depth", out_depth, h_dep);
                chk("hold_color", out_color, h_col);
            end
            held = 1'b0;
            if (mem_en && t_mem < 0) t_mem = cyc;
            if (out_valid && t_val < 0) t_val = cyc;
            if (done) begin
                seen   = 1'b1;
                f_emit = int'(emit_count);
                f_cull = int'(cull_count);
            end else begin
                start     = poke && busy && (cyc == 30 || cyc == 150);
                out_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
                if (out_valid && out_ready) begin
                    q_tri.push_back(out_tri);
                    q_col.push_back(out_color);
                    q_dep.push_back(out_depth);
                end else if (out_valid) begin
                    held  = 1'b1;
                    h_tri = out_tri;
                    h_dep = out_depth;
                    h_col = out_color;
                end
                @(negedge clk);
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (!seen) chk("done_timeout", 0, 1);
        lat        = t_val - t_mem;
        frame_divs = div_starts - d0;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        bit hit;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        cam_pos     = '0;
        sin_val     = 8'd0;
        cos_val     = 8'd64;
        backface_en = 1'b1;
        for (int i = 0; i < NT; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_emit", emit_count, 0);
        chk("rst_cull", cull_count, 0);
        chk("rst_tri", out_tri, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        mem[0] = tri_word(4, 2, 8, -4, 2, 8, 0, -6, 8, 'h155);
        run_frame(0, 0);
        chk("id_n", q_tri.size(), 1);
        chk_tri("id", 0, 8, 4, -8, 4, 0, -12);
        chk("id_depth", (q_dep.size() > 0) ? q_dep[0] : 0, 8);
        chk("id_color", (q_col.size() > 0) ? q_col[0] : 0, 'h155);
        chk("id_emit", f_emit, 1);
        chk("id_cull", f_cull, 3);
        chk("id_latency", lat, LAT);
        chk("id_divs", frame_divs, 6);

        mem[0] = tri_word(4, 2, 8, 0, -6, 8, -4, 2, 8, 'h0aa);
        run_frame(0, 0);
        chk("bf_n", q_tri.size(), 0);
        chk("bf_emit", f_emit, 0);
        chk("bf_cull", f_cull, 4);
        backface_en = 1'b0;
        run_frame(0, 0);
        chk("nobf_n", q_tri.size(), 1);
        chk_tri("nobf", 0, 8, 4, 0, -12, -8, 4);
        chk("nobf_emit", f_emit, 1);

        sin_val = 8'd64;
        cos_val = 8'd0;
        mem[0]  = tri_word(8, 0, -4, 4, 2, 0, 2, -3, -1, 1);
        run_frame(0, 0);
        chk("rot_n", q_tri.size(), 1);
        chk_tri("rot", 0, 8, 0, 0, 8, 8, -24);
        chk("rot_depth", (q_dep.size() > 0) ? q_dep[0] : 0, 8);

        sin_val = 8'd0;
        cos_val = 8'd64;
        mem[0]  = tri_word(-5, 0, 3, 31, 1, 1, -32, -7, 1, 2);
        run_frame(0, 0);
        chk("ts_n", q_tri.size(), 1);
        chk_tri("ts", 0, -26, 0, 255, 16, -256, -112);
        chk("ts_depth", (q_dep.size() > 0) ? q_dep[0] : 0, 3);

        backface_en = 1'b1;
        cam_pos     = {7'sd0, 7'sd0, 7'sd8};
        for (int i = 0; i < NT; i++)
            mem[i] = tri_word(4, 2, 16, -4, 2, 16, 0, -6, 8, 3);
        run_frame(0, 0);
        chk("near_n", q_tri.size(), 0);
        chk("near_cull", f_cull, 4);
        chk("near_divs", frame_divs, 0);

        cam_pos = '0;
        for (int i = 0; i < NT; i++)
            mem[i] = tri_word(4 + i, 2, 8, -4, 2, 8, 0, -6, 8, i + 1);
        run_frame(1, 1);
        chk("bp_n", q_tri.size(), 4);
        for (int i = 0; i < NT; i++) begin
            chk("bp_color", (i < q_col.size()) ? q_col[i] : 0, i + 1);
            chk("bp_x0", (i < q_tri.size()) ? fld(q_tri[i], 0) : 0,
                2 * (4 + i));
        end
        chk("bp_emit", f_emit, 4);
        chk("bp_cull", f_cull, 0);

        mem[0] = tri_word(4, 2, 8, -4, 2, 8, 0, -6, 8, 5);
        mem[1] = tri_word(4, 2, 8, -4, 2, 8, 0, -6, 8, 6);
        mem[2] = '0;
        mem[3] = '0;
        hit    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            @(negedge clk);
            if (emit_count == 1 && dut.u_div.busy) hit = 1'b1;
        end
        chk("mid_div_reach", hit, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_emit", emit_count, 0);
        chk("mr_cull", cull_count, 0);
        rst_n = 1'b1;
        run_frame(0, 0);
        chk("mr_n", q_tri.size(), 2);
        chk("mr_x0", (q_tri.size() > 0) ? fld(q_tri[0], 0) : 0, 8);
        chk("mr_fresh_emit", f_emit, 2);
        chk("mr_fresh_cull", f_cull, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
